// File: rtl/led_strip_top.sv
// led_strip_top: drives a WS2812-style LED strip on PIN_1 with an animated
// green/red gradient. Each frame is a low latch gap followed by NUM_LEDS
// 24-bit GRB pixel words, one NRZ-encoded bit every BIT_CYCLES clocks. LED
// mirrors transmit activity, and USBPU keeps the USB pull-up disabled.
module led_strip_top #(
   parameter int NUM_LEDS     = 8,
   parameter int BIT_CYCLES   = 20,
   parameter int T0H_CYCLES   = 6,
   parameter int T1H_CYCLES   = 13,
   parameter int RESET_CYCLES = 1000
) (
   input  logic CLK,
   input  logic RESET_N,
   output logic LED,
   output logic PIN_1,
   output logic USBPU
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   typedef enum logic {LATCH = 1'b0, SEND = 1'b1} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [LW-1:0]   latch_cnt;
   logic [CW-1:0]   cyc_cnt;
   logic [4:0]      bit_idx;
   logic [7:0]      pix_idx;
   logic [7:0]      frame;

   logic [7:0]      green;
   logic [23:0]     pixel_word;
   logic            cur_bit;
   logic            latch_done;
   logic            bit_last;
   logic            word_last;
   logic            frame_last;
   logic            pin_nxt;

   assign USBPU = 1'b0;

   // Pattern for the pixel being sent and the end-of-bit/word/frame strobes.
   always_comb begin
      // NOTE: every signal gets a default first so no latch can be inferred.
      green      = frame + {pix_idx[2:0], 5'b0_0000};
      pixel_word = {green, ~green, 8'h10};
      cur_bit    = pixel_word[5'd23 - bit_idx];
      latch_done = (latch_cnt == LW'(RESET_CYCLES - 1));
      bit_last   = (cyc_cnt == CW'(BIT_CYCLES - 1));
      word_last  = bit_last && (bit_idx == 5'd23);
      frame_last = word_last && (pix_idx == 8'(NUM_LEDS - 1));
      pin_nxt    = (state == SEND) &&
                   (cyc_cnt < (cur_bit ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
   end

   // Next-state logic: latch gap, then one full frame of pixels.
   always_comb begin
      state_nxt = state;
      case (state)
         LATCH:   if (latch_done) state_nxt = SEND;
         SEND:    if (frame_last) state_nxt = LATCH;
         default: state_nxt = LATCH;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!RESET_N) state <= LATCH;
      else          state <= state_nxt;
   end

   // Latch, bit-period, bit, pixel and frame counters.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         latch_cnt <= '0;
         cyc_cnt   <= '0;
         bit_idx   <= '0;
         pix_idx   <= '0;
         frame     <= '0;
      end else if (state == LATCH) begin
         latch_cnt <= latch_done ? '0 : latch_cnt + LW'(1);
      end else begin
         latch_cnt <= '0;
         cyc_cnt   <= bit_last ? '0 : cyc_cnt + CW'(1);
         if (bit_last)   bit_idx <= (bit_idx == 5'd23) ? 5'd0 : bit_idx + 5'd1;
         if (word_last)  pix_idx <= frame_last ? 8'd0 : pix_idx + 8'd1;
         if (frame_last) frame   <= frame + 8'd1;
      end
   end

   // Registered outputs so the strip and indicator see glitch-free levels.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         PIN_1 <= 1'b0;
         LED   <= 1'b0;
      end else begin
         PIN_1 <= pin_nxt;
         LED   <= (state == SEND);
      end
   end

endmodule

// File: tb/tb_led_strip_top.sv
// tb_led_strip_top: runs a default strip instance and a shortened one side by
// side. Both are compared every cycle against a timing model that works from
// the edge count since reset release. Decoded pixels and directed literals
// pin that model to known values.
module tb_led_strip_top;

   localparam int M_N = 8, M_B = 20, M_T0 = 6, M_T1 = 13, M_R = 1000;
   localparam int W_N = 1, W_B = 4,  W_T0 = 1, W_T1 = 2,  W_R = 10;
   localparam int M_SEND = 24 * M_N * M_B;
   localparam int W_SEND = 24 * W_N * W_B;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_m = 1'b0;
   logic rst_w = 1'b0;
   logic led_m, pin_m, usb_m;
   logic led_w, pin_w, usb_w;

   int vectors     = 0;
   int miscompares = 0;
   int n_m = 0;
   int n_w = 0;

   // Recorder state for the main instance (frames 0 and 1).
   bit rec_m_on = 1'b1;
   int m_rise = 0, m_idx = 0, m_first_n = 0, m_gap = 0;
   int m_len [2];
   int hc [2][M_SEND / M_B];
   logic m_prev = 1'b0;

   // Recorder state for the shortened instance (frame 256).
   int w_rise = 0, w_idx = 0;
   bit w_done = 1'b0;
   int hcw [24];
   logic w_prev = 1'b0;

   led_strip_top dut_m (
      .CLK(clk), .RESET_N(rst_m), .LED(led_m), .PIN_1(pin_m), .USBPU(usb_m)
   );

   led_strip_top #(
      .NUM_LEDS(W_N), .BIT_CYCLES(W_B), .T0H_CYCLES(W_T0),
      .T1H_CYCLES(W_T1), .RESET_CYCLES(W_R)
   ) dut_w (
      .CLK(clk), .RESET_N(rst_w), .LED(led_w), .PIN_1(pin_w), .USBPU(usb_w)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] model_word(input int f, input int pix);
      int g;
      int r;
      g = (f + 32 * pix) % 256;
      r = 255 - g;
      return {g[7:0], r[7:0], 8'h10};
   endfunction

   // {LED, PIN_1} after n rising edges since reset release.
   function automatic logic [1:0] model_out(input int n, input int nl, input int bc,
                                            input int t0, input int t1, input int rc);
      int m, period, pos, f, s, pix, bn, c;
      logic [23:0] w;
      if (n <= 0) return 2'b00;
      m      = n - 1;
      period = rc + 24 * nl * bc;
      pos    = m % period;
      f      = (m / period) % 256;
      if (pos < rc) return 2'b00;
      s   = pos - rc;
      pix = s / (24 * bc);
      bn  = (s / bc) % 24;
      c   = s % bc;
      w   = model_word(f, pix);
      return {1'b1, (c < (w[23 - bn] ? t1 : t0))};
   endfunction

   // Edge counters since reset release.
   initial forever begin
      @(posedge clk);
      n_m = rst_m ? n_m + 1 : 0;
      n_w = rst_w ? n_w + 1 : 0;
   end

   // Per-cycle comparison against the model, plus waveform recorders.
   initial forever begin
      @(negedge clk);
      check($sformatf("main_out@%0d", n_m), {29'd0, led_m, pin_m, usb_m},
            {29'd0, model_out(n_m, M_N, M_B, M_T0, M_T1, M_R), 1'b0});
      check($sformatf("wrap_out@%0d", n_w), {29'd0, led_w, pin_w, usb_w},
            {29'd0, model_out(n_w, W_N, W_B, W_T0, W_T1, W_R), 1'b0});
      if (rec_m_on) begin
         if (led_m && !m_prev) begin
            m_rise++;
            m_idx = 0;
            if (m_rise == 1) m_first_n = n_m;
         end
         if (led_m && m_rise >= 1 && m_rise <= 2) begin
            if (m_idx < M_SEND) begin
               if (pin_m) hc[m_rise - 1][m_idx / M_B]++;
               m_idx++;
            end
            m_len[m_rise - 1]++;
         end
         if (!led_m && m_rise == 1) m_gap++;
         m_prev = led_m;
      end
      if (led_w && !w_prev) begin
         w_rise++;
         w_idx = 0;
      end
      if (led_w && w_rise == 257 && w_idx < W_SEND) begin
         if (pin_w) hcw[w_idx / W_B]++;
         w_idx++;
         if (w_idx == W_SEND) w_done = 1'b1;
      end
      w_prev = led_w;
   end

   function automatic logic [23:0] decode_main(input int fr, input int pix);
      logic [23:0] w;
      w = '0;
      for (int b = 0; b < 24; b++) w[23 - b] = (hc[fr][pix * 24 + b] == M_T1);
      return w;
   endfunction

   initial begin
      int k;
      logic [23:0] lit;
      logic [23:0] wd;
      m_len[0] = 0;
      m_len[1] = 0;
      for (int f = 0; f < 2; f++)
         for (int b = 0; b < M_SEND / M_B; b++) hc[f][b] = 0;
      for (int b = 0; b < 24; b++) hcw[b] = 0;

      // Model anchors against hand-computed values.
      check("model_f0p0", model_word(0, 0), 24'h00FF10);
      check("model_f0p1", model_word(0, 1), 24'h20DF10);
      check("model_f9p7", model_word(9, 7), 24'hE91610);
      check("model_n1000", model_out(1000, M_N, M_B, M_T0, M_T1, M_R), 2'b00);
      check("model_n1001", model_out(1001, M_N, M_B, M_T0, M_T1, M_R), 2'b11);
      check("model_n1007", model_out(1007, M_N, M_B, M_T0, M_T1, M_R), 2'b10);

      // Reset hold.
      repeat (10) begin
         @(negedge clk);
         check("rst_hold_out", {29'd0, led_m, pin_m, usb_m}, 32'd0);
      end
      rst_m = 1'b1;
      rst_w = 1'b1;

      // Run the main instance into frame 2.
      k = 0;
      while (m_rise < 3 && k < 12000) begin
         @(negedge clk);
         k++;
      end
      check("frame2_reached", {31'd0, m_rise >= 3}, 32'd1);
      check("first_rise_edge", m_first_n, 32'd1001);
      check("frame0_send_len", m_len[0], 32'd3840);
      check("frame0_latch_gap", m_gap, 32'd1000);
      check("frame1_send_len", m_len[1], 32'd3840);

      lit = 24'h00FF10;
      for (int b = 0; b < 24; b++)
         check($sformatf("f0p0_bit%0d_high", b), hc[0][b], lit[23 - b] ? 32'd13 : 32'd6);
      check("f0p1_word", decode_main(0, 1), 24'h20DF10);
      check("f0p7_word", decode_main(0, 7), 24'hE01F10);
      check("f1p0_word", decode_main(1, 0), 24'h01FE10);

      // Reset mid-SEND while PIN_1 is high.
      k = 0;
      while (!(pin_m && led_m) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("midsend_pin_high", {30'd0, led_m, pin_m}, 32'd3);
      rec_m_on = 1'b0;
      #1 rst_m = 1'b0;
      #1;
      check("midsend_async_out", {29'd0, led_m, pin_m, usb_m}, 32'd0);
      repeat (5) @(negedge clk);
      rst_m = 1'b1;
      k = 0;
      while (!led_m && k < 1100) begin
         @(negedge clk);
         k++;
      end
      check("restart_rise_edge", n_m, 32'd1001);

      // Frame-counter wrap on the shortened instance.
      k = 0;
      while (!w_done && k < 32000) begin
         @(negedge clk);
         k++;
      end
      check("wrap_frame256_reached", {31'd0, w_done}, 32'd1);
      wd = '0;
      for (int b = 0; b < 24; b++) wd[23 - b] = (hcw[b] == W_T1);
      check("wrap_f256p0_word", wd, 24'h00FF10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/led_strip_top.md
Name: led_strip_top

Overview:
- Top-level block for a TinyFPGA board that drives a WS2812-style addressable LED strip on PIN_1 with a self-generated, frame-animated colour pattern.
- Shows transmit activity on the on-board LED.
- Holds the USB pull-up (USBPU) permanently inactive.
- Contains a latch/reset timer, a serial bit encoder and a pattern generator. No external data interface.

Parameters:
- NUM_LEDS, 8: pixels per frame (1..255).
- BIT_CYCLES, 20: CLK cycles per encoded bit (1.25 us at 16 MHz).
- T0H_CYCLES, 6: high time of a '0' bit, in cycles.
- T1H_CYCLES, 13: high time of a '1' bit, in cycles.
- RESET_CYCLES, 1000: low latch gap before each frame, in cycles.
- Legality: 1 <= T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; RESET_CYCLES >= 1. Illegal values need not be supported.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- LED  output  1  activity indicator; high while a frame is being transmitted.
- PIN_1  output  1  serial strip data (WS2812 NRZ encoding).
- USBPU  output  1  USB pull-up control; constant 0.

Behaviour:
- Clocking and reset: one clock (CLK); reset RESET_N is asynchronous, active-low.
- Outputs while RESET_N=0: PIN_1=0, LED=0, USBPU=0. State=LATCH, latch counter=0, frame counter=0, pixel index=0, bit index=0.
- USBPU is tied 0 at all times, independent of reset.
- PIN_1 and LED are registered outputs, with no combinational path from inputs.
- States: LATCH, SEND.
  - LATCH: PIN_1=0, LED=0 for exactly RESET_CYCLES cycles, then go to SEND.
  - The first PIN_1 rising edge after reset release occurs on the (RESET_CYCLES+1)th rising CLK edge after RESET_N goes high.
  - SEND: transmit NUM_LEDS pixels, 24 bits each, pixel 0 first. LED=1 for the whole SEND state.
- Bit encoding, for each bit period of BIT_CYCLES cycles:
  - PIN_1=1 for T1H_CYCLES cycles if the bit is 1, else T0H_CYCLES cycles.
  - PIN_1=0 for the remainder of the period.
  - Bits are back-to-back, with no gap between bits or pixels.
- Pixel word: 24 bits in order G[7:0], R[7:0], B[7:0], MSB first.
- Pattern, with F = 8-bit frame counter and i = pixel index:
  - G = (F + 32*i) mod 256
  - R = 255 - G
  - B = 0x10
  - All arithmetic is 8-bit unsigned, wrapping.
- Frame length: 24*NUM_LEDS*BIT_CYCLES SEND cycles, followed by RESET_CYCLES LATCH cycles.
- End of frame: after the last cycle of the last bit of pixel NUM_LEDS-1:
  - return to LATCH;
  - F increments, wrapping 255 -> 0;
  - pixel and bit indices clear.
- Pixel data is computed or loaded before its first bit begins. No bubble cycles between pixels.
- Reset mid-frame: outputs drop to reset values immediately (asynchronously). The partial frame is abandoned. After release, operation restarts with LATCH and F=0.
- Free-running: there are no inputs besides CLK and RESET_N.

Test Plan:
- Reset hold: RESET_N=0 for 10 cycles -> PIN_1=0, LED=0, USBPU=0 throughout. Assert RESET_N low mid-SEND -> PIN_1 and LED go 0 before the next clock edge.
- Latch timing: release reset -> PIN_1=0 and LED=0 for 1000 cycles. PIN_1 and LED rise on the 1001st edge.
- Frame 0, pixel 0 encoding: first 8 bits (G=0x00) are each 6 cycles high / 14 low. Next 8 bits (R=0xFF) are 13 high / 7 low. B=0x10: bit 4 (the 4th B bit sent) is 13 high; the other B bits are 6 high.
- Pixel 1 of frame 0: G=0x20, R=0xDF, B=0x10 decoded from PIN_1 starting at cycle 480 of SEND. Pixel 7: G=0xE0, R=0x1F.
- Frame boundary: SEND lasts exactly 3840 cycles with LED=1, then 1000 cycles low. Frame 1 pixel 0 decodes as G=0x01, R=0xFE, B=0x10.
- Wrap: run 256 frames (shorten RESET_CYCLES=10, NUM_LEDS=1, BIT_CYCLES=4, T0H=1, T1H=2) -> frame 256 pixel 0 decodes G=0x00, R=0xFF again. USBPU stays 0 throughout.
